// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM mux/demux link: frame tracker states,
// slot indices and the slot-advance helper.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  localparam int unsigned NUM_SLOTS = 4;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  function automatic logic [1:0] next_slot(input logic [1:0] s);
    return 2'((32'(s) + 1) % NUM_SLOTS);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-4 slot counter with enable and synchronous load; shared with the
// transmit-side mux sequencer. Load takes priority over enable.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] cnt
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = next_slot(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= SLOT_A;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tdm_demux_1to4.sv
// 1-to-4 TDM demultiplexer with frame lock; outputs update atomically per frame.
// Define TDM_DEMUX_SYNC_CHECK_EN to enable framing-error detection in LOCKED.
module tdm_demux_1to4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  tdm_state_e       state_q, state_d;
  logic [WIDTH-1:0] shadow_a_q, shadow_a_d;
  logic [WIDTH-1:0] shadow_b_q, shadow_b_d;
  logic [WIDTH-1:0] shadow_c_q, shadow_c_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  logic             cnt_en, cnt_load;
  logic [1:0]       cnt_load_val;
  logic [1:0]       slot_cur;
  logic             frm_err;

  tdm_slot_counter u_slot_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .cnt      (slot_cur)
  );

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  assign frm_err = (frame_sync && (slot_cur != SLOT_A)) ||
                   (!frame_sync && (slot_cur == SLOT_A));
`else
  assign frm_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    shadow_a_d    = shadow_a_q;
    shadow_b_d    = shadow_b_q;
    shadow_c_d    = shadow_c_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    cnt_en        = 1'b0;
    cnt_load      = 1'b0;
    cnt_load_val  = SLOT_A;

    unique case (state_q)
      HUNT: begin
        if (in_valid && frame_sync) begin
          shadow_a_d   = din;
          cnt_load     = 1'b1;
          cnt_load_val = SLOT_B;
          state_d      = LOCKED;
        end
      end

      LOCKED: begin
        if (in_valid) begin
          if (frm_err) begin
            // Drop the partial frame; a sync-carrying beat restarts it at slot 0.
            sync_err_d = 1'b1;
            cnt_load   = 1'b1;
            if (frame_sync) begin
              shadow_a_d   = din;
              cnt_load_val = SLOT_B;
            end else begin
              cnt_load_val = SLOT_A;
              state_d      = HUNT;
            end
          end else begin
            cnt_en = 1'b1;
            unique case (slot_cur)
              SLOT_A: shadow_a_d = din;
              SLOT_B: shadow_b_d = din;
              SLOT_C: shadow_c_d = din;
              SLOT_D: begin
                a_d           = shadow_a_q;
                b_d           = shadow_b_q;
                c_d           = shadow_c_q;
                d_d           = din;
                frame_valid_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      shadow_a_q    <= '0;
      shadow_b_q    <= '0;
      shadow_c_q    <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_a_q    <= shadow_a_d;
      shadow_b_q    <= shadow_b_d;
      shadow_c_q    <= shadow_c_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_cur;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed bench for tdm_demux_1to4; misaligned-sync case runs only when
// TDM_DEMUX_SYNC_CHECK_EN is defined.
module tb_tdm_demux_1to4;

  localparam int unsigned W = 1;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         in_valid;
  logic         frame_sync;
  logic [W-1:0] a, b, c, d;
  logic         frame_valid;
  logic [1:0]   slot;
  logic         locked;
  logic         sync_err;

  int unsigned total;
  int unsigned bad;

  tdm_demux_1to4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .in_valid    (in_valid),
    .frame_sync  (frame_sync),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] exp_abcd, input logic exp_fv);
    chk({tag, ".abcd"}, 32'({a, b, c, d}), 32'(exp_abcd));
    chk({tag, ".fv"}, 32'(frame_valid), 32'(exp_fv));
  endtask

  // One valid beat: driven at negedge, sampled 1 time unit after the capturing edge.
  task automatic beat(input logic v, input logic fs);
    @(negedge clk);
    din        = v;
    in_valid   = 1'b1;
    frame_sync = fs;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    din        = '0;
    in_valid   = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst", 4'b0000, 1'b0);
    chk("rst.slot", 32'(slot), 0);
    chk("rst.locked", 32'(locked), 0);
    chk("rst.sync_err", 32'(sync_err), 0);
    release_reset();

    // Reset then acquire: lock, reset mid-stream, then a clean frame 1,1,1,0.
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    chk("pre.slot", 32'(slot), 2);
    do_reset();
    chk("midrst.locked", 32'(locked), 0);
    chk("midrst.slot", 32'(slot), 0);
    release_reset();
    beat(1'b1, 1'b1);
    chk("acq1.locked", 32'(locked), 1);
    chk("acq1.slot", 32'(slot), 1);
    chk_out("acq1", 4'b0000, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    chk_out("acq3", 4'b0000, 1'b0);
    beat(1'b0, 1'b0);
    chk_out("acq4", 4'b1110, 1'b1);
    chk("acq4.slot", 32'(slot), 0);
    idle(1);
    chk_out("acq.after", 4'b1110, 1'b0);
    chk("acq.sync_err", 32'(sync_err), 0);

    // Pre-sync garbage is discarded while hunting.
    do_reset();
    release_reset();
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    chk("garb.locked", 32'(locked), 0);
    chk("garb.slot", 32'(slot), 0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    chk_out("garb.frame", 4'b0001, 1'b1);

    // Gapped frame 0,0,1,0: outputs hold through the gaps.
    beat(1'b0, 1'b1);
    idle(2);
    chk_out("gap1", 4'b0001, 1'b0);
    chk("gap1.slot", 32'(slot), 1);
    beat(1'b0, 1'b0);
    idle(2);
    chk_out("gap2", 4'b0001, 1'b0);
    beat(1'b1, 1'b0);
    idle(2);
    chk_out("gap3", 4'b0001, 1'b0);
    chk("gap3.slot", 32'(slot), 3);
    beat(1'b0, 1'b0);
    chk_out("gap.frame", 4'b0010, 1'b1);
    idle(1);
    chk_out("gap.after", 4'b0010, 1'b0);

    // Back-to-back frames 1,1,0,1 and 0,1,0,0 at full rate.
    beat(1'b1, 1'b1);
    chk_out("b2b.1", 4'b0010, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    chk_out("b2b.3", 4'b0010, 1'b0);
    beat(1'b1, 1'b0);
    chk_out("b2b.4", 4'b1101, 1'b1);
    beat(1'b0, 1'b1);
    chk_out("b2b.5", 4'b1101, 1'b0);
    beat(1'b1, 1'b0);
    chk_out("b2b.6", 4'b1101, 1'b0);
    beat(1'b0, 1'b0);
    chk_out("b2b.7", 4'b1101, 1'b0);
    beat(1'b0, 1'b0);
    chk_out("b2b.8", 4'b0100, 1'b1);

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    // frame_sync on slot 2 restarts the frame; that beat becomes the new slot 0.
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b1);
    chk("mis.sync_err", 32'(sync_err), 1);
    chk_out("mis.err", 4'b0100, 1'b0);
    chk("mis.slot", 32'(slot), 1);
    chk("mis.locked", 32'(locked), 1);
    beat(1'b0, 1'b0);
    chk("mis.err_clr", 32'(sync_err), 0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    chk_out("mis.frame", 4'b1000, 1'b1);
    chk("mis.sync_err2", 32'(sync_err), 0);
`endif

    // Reset after two beats of a frame, then frame 0,1,1,1.
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    do_reset();
    chk_out("rst2", 4'b0000, 1'b0);
    chk("rst2.locked", 32'(locked), 0);
    chk("rst2.slot", 32'(slot), 0);
    release_reset();
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    chk_out("rst2.frame", 4'b0111, 1'b1);
    chk("rst2.locked2", 32'(locked), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1to4.md
# tdm_demux_1to4

Receive-side counterpart of the 4-to-1 channel multiplexer. It accepts a time-division-multiplexed stream carrying four channels (a, b, c, d) in rotating slots (`sel` order 00, 01, 10, 11) and locks onto frame boundaries. It demultiplexes each complete frame into four registered channel outputs that update atomically. It sits at the far end of a serialised mux link, feeding per-channel consumers.

## Interface
- WIDTH, 1, bits per channel sample
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- din  input  WIDTH  TDM sample for the current slot
- in_valid  input  1  din is a valid slot beat this cycle
- frame_sync  input  1  qualifies the beat carrying slot 0 (channel a); meaningful only with in_valid
- a, b, c, d  output  WIDTH  demultiplexed channel samples, held between frames
- frame_valid  output  1  one-cycle pulse when a, b, c, d update
- slot  output  2  slot index expected on the next valid beat
- locked  output  1  high while the frame tracker is in LOCKED
- sync_err  output  1  one-cycle pulse on a detected framing error (compiled only with the check)

Clock and reset are fixed: one clock `clk`; asynchronous active-low reset `rst_n`.

## Operation
- States are HUNT and LOCKED. Reset enters HUNT.
- Reset values: a, b, c, d = 0; frame_valid = 0; slot = 0; locked = 0; sync_err = 0; shadow registers = 0.
- HUNT:
  - Beats are discarded until in_valid && frame_sync.
  - That beat is stored as slot 0 into shadow_a. slot becomes 1 and the state goes to LOCKED.
- LOCKED:
  - Each in_valid beat is stored into the shadow register for the current slot, then slot increments modulo 4.
  - On the slot-3 beat, a ← shadow_a, b ← shadow_b, c ← shadow_c and d ← din all load in the same edge. frame_valid pulses and slot wraps to 0.
- in_valid low: nothing changes; slot holds. Gaps of any length inside a frame are legal.
- Outputs a..d never show a partially assembled frame.
- frame_sync on a beat with in_valid low is ignored.
- Reset mid-frame: partial shadow contents are discarded, the state returns to HUNT, and a..d clear to 0.

## Timing
- Latency: a..d and frame_valid are visible in the cycle after the edge that samples the slot-3 beat, i.e. one clock after the last beat.
- Throughput: one slot per cycle, so one frame per 4 cycles at a sustained in_valid.
- frame_valid is never high in two consecutive cycles while in_valid is continuous (minimum spacing is 4 cycles).
- slot is registered and reflects the next expected slot.

## Configuration
- Macro: TDM_DEMUX_SYNC_CHECK_EN.
- Defined:
  - In LOCKED, frame_sync on a valid beat with slot ≠ 0 is an error. So is a slot-0 valid beat without frame_sync.
  - On error: sync_err pulses for one cycle, the partial frame is dropped, and no frame_valid is issued for it.
  - If the offending beat carries frame_sync, it is taken as a new slot 0 (slot → 1, stay LOCKED). Otherwise the state goes to HUNT.
- Undefined:
  - frame_sync is used only for acquisition in HUNT. Once LOCKED, the block free-runs on the slot counter.
  - sync_err is tied to 0.

## Structure
- A shared package tdm_pkg holds:
  - the state enumeration (HUNT, LOCKED)
  - slot constants SLOT_A=0, SLOT_B=1, SLOT_C=2, SLOT_D=3
  - NUM_SLOTS=4
- One sub-module, tdm_slot_counter: a modulo-4 counter with enable and synchronous load-to-value. It is reused by the transmit-side mux sequencer.

## Test plan
- Reset then acquire: assert rst_n low mid-stream, release, and drive 4 valid beats 1,1,1,0 with frame_sync on the first → a=1, b=1, c=1, d=0, frame_valid pulses once, locked=1.
- Pre-sync garbage: 3 valid beats without frame_sync, then frame 0,0,0,1 with sync → the garbage is ignored; a=0, b=0, c=0, d=1.
- Gapped frame: beats 0,0,1,0 with in_valid low for 2 cycles between beats → a..d hold their old values until the last beat, then become 0,0,1,0. Exactly one frame_valid.
- Back-to-back frames at full rate: 1,1,0,1 then 0,1,0,0 → frame_valid 4 cycles apart. Each frame appears in one cycle and never mixes values from two frames.
- Misaligned sync (with TDM_DEMUX_SYNC_CHECK_EN): frame_sync on slot 2 → sync_err pulses and there is no frame_valid for that frame. The next 4 beats 1,0,0,0 yield a=1, b=0, c=0, d=0.
- Reset mid-frame after 2 beats → a..d=0, locked=0, slot=0. The next synced frame 0,1,1,1 decodes correctly.
